// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - icache/dcache memory arbiter with tag owner table (optional ARB_STARVE_GUARD_EN)
module mem_arbiter #(
    parameter int STARVE_LIMIT = 4
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [1:0]  proc2Imem_command,
    input  logic [63:0] proc2Imem_addr,
    input  logic [1:0]  proc2Dmem_command,
    input  logic [63:0] proc2Dmem_addr,
    input  logic [63:0] proc2Dmem_data,
    output logic [3:0]  Imem2proc_response,
    output logic [63:0] Imem2proc_data,
    output logic [3:0]  Imem2proc_tag,
    output logic [3:0]  Dmem2proc_response,
    output logic [63:0] Dmem2proc_data,
    output logic [3:0]  Dmem2proc_tag,
    output logic [1:0]  proc2mem_command,
    output logic [63:0] proc2mem_addr,
    output logic [63:0] proc2mem_data,
    input  logic [3:0]  mem2proc_response,
    input  logic [63:0] mem2proc_data,
    input  logic [3:0]  mem2proc_tag,
    output logic [3:0]  I_outstanding,
    output logic [3:0]  D_outstanding,
    output logic        orphan_tag
);
    localparam logic [1:0] BUS_NONE = 2'd0;
    localparam logic [1:0] BUS_LOAD = 2'd1;

    if (STARVE_LIMIT < 1 || STARVE_LIMIT > 255) begin : g_bad_limit
        $error("mem_arbiter: STARVE_LIMIT must be in 1..255");
    end

    logic        i_req, d_req, grant_i, grant_d;
    logic        alloc, comp;
    logic [15:0] valid_q, valid_d, owner_q, owner_d;   // owner bit 1 = dcache
    logic [3:0]  i_cnt_d, d_cnt_d;
    logic        orphan_d;

    // Both requests are gated by reset so every combinational output reads 0 while held.
    assign i_req = reset && (proc2Imem_command != BUS_NONE);
    assign d_req = reset && (proc2Dmem_command != BUS_NONE);

`ifdef ARB_STARVE_GUARD_EN
    logic [7:0] starve_q, starve_d;
    logic       force_i;

    assign force_i = i_req && (starve_q >= 8'(STARVE_LIMIT));
    assign grant_i = i_req && (!d_req || force_i);

    always_comb begin
        starve_d = starve_q;
        if (!i_req || force_i || (grant_i && mem2proc_response != 4'd0))
            starve_d = 8'd0;
        else if (starve_q < 8'(STARVE_LIMIT))
            starve_d = starve_q + 8'd1;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) starve_q <= 8'd0;
        else        starve_q <= starve_d;
    end
`else
    assign grant_i = i_req && !d_req;
`endif
    assign grant_d = d_req && !grant_i;

    always_comb begin
        proc2mem_command = BUS_NONE;
        proc2mem_addr    = 64'd0;
        proc2mem_data    = 64'd0;
        if (grant_d) begin
            proc2mem_command = proc2Dmem_command;
            proc2mem_addr    = proc2Dmem_addr;
            proc2mem_data    = proc2Dmem_data;
        end else if (grant_i) begin
            proc2mem_command = proc2Imem_command;
            proc2mem_addr    = proc2Imem_addr;
        end
    end

    assign Imem2proc_response = grant_i ? mem2proc_response : 4'd0;
    assign Dmem2proc_response = grant_d ? mem2proc_response : 4'd0;

    // Stores never come back with data, so they never own a tag.
    assign alloc = (proc2mem_command == BUS_LOAD) && (mem2proc_response != 4'd0);
    assign comp  = reset && (mem2proc_tag != 4'd0);

    always_comb begin
        Imem2proc_tag  = 4'd0;
        Imem2proc_data = 64'd0;
        Dmem2proc_tag  = 4'd0;
        Dmem2proc_data = 64'd0;
        if (comp && valid_q[mem2proc_tag]) begin
            if (owner_q[mem2proc_tag]) begin
                Dmem2proc_tag  = mem2proc_tag;
                Dmem2proc_data = mem2proc_data;
            end else begin
                Imem2proc_tag  = mem2proc_tag;
                Imem2proc_data = mem2proc_data;
            end
        end
    end

    // Completion is retired before allocation so a same-cycle reuse of a tag installs the new owner.
    always_comb begin
        valid_d  = valid_q;
        owner_d  = owner_q;
        orphan_d = 1'b0;
        if (comp) begin
            if (valid_q[mem2proc_tag]) valid_d[mem2proc_tag] = 1'b0;
            else                       orphan_d = 1'b1;
        end
        if (alloc) begin
            if (valid_d[mem2proc_response]) orphan_d = 1'b1;
            valid_d[mem2proc_response] = 1'b1;
            owner_d[mem2proc_response] = grant_d;
        end
        valid_d[0] = 1'b0;
        owner_d[0] = 1'b0;
        i_cnt_d = 4'd0;
        d_cnt_d = 4'd0;
        for (int k = 1; k < 16; k++) begin
            if (valid_d[k]) begin
                if (owner_d[k]) d_cnt_d = d_cnt_d + 4'd1;
                else            i_cnt_d = i_cnt_d + 4'd1;
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            valid_q       <= 16'd0;
            owner_q       <= 16'd0;
            I_outstanding <= 4'd0;
            D_outstanding <= 4'd0;
            orphan_tag    <= 1'b0;
        end else begin
            valid_q       <= valid_d;
            owner_q       <= owner_d;
            I_outstanding <= i_cnt_d;
            D_outstanding <= d_cnt_d;
            orphan_tag    <= orphan_d;
        end
    end
endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter STARVE_LIMIT, default 4: consecutive icache denials before forced icache grant (guard build only).
REQ-002 SHALL have port clock  in  1  single clock, all state on posedge.
REQ-003 SHALL have port reset  in  1  asynchronous, active-low reset.
REQ-004 SHALL have ports proc2Imem_command in 2, proc2Imem_addr in 64: icache request (BUS_NONE/BUS_LOAD).
REQ-005 SHALL have ports proc2Dmem_command in 2, proc2Dmem_addr in 64, proc2Dmem_data in 64: dcache request (BUS_NONE/BUS_LOAD/BUS_STORE).
REQ-006 SHALL have ports Imem2proc_response out 4, Imem2proc_data out 64, Imem2proc_tag out 4: icache-side view of memory.
REQ-007 SHALL have ports Dmem2proc_response out 4, Dmem2proc_data out 64, Dmem2proc_tag out 4: dcache-side view.
REQ-008 SHALL have ports proc2mem_command out 2, proc2mem_addr out 64, proc2mem_data out 64: shared memory request.
REQ-009 SHALL have ports mem2proc_response in 4, mem2proc_data in 64, mem2proc_tag in 4: shared memory reply; 0 = none/busy.
REQ-010 SHALL have ports I_outstanding out 4, D_outstanding out 4: live owned-tag counts per requester.
REQ-011 SHALL have port orphan_tag out 1: registered one-cycle pulse, completion for an unowned tag.

Function
REQ-012 SHALL select at most one requester per cycle, combinationally; request and response same cycle (zero latency).
REQ-013 SHALL grant dcache when proc2Dmem_command != BUS_NONE, else icache when proc2Imem_command != BUS_NONE, else none (BUS_NONE, addr/data 0).
REQ-014 SHALL drive proc2mem_* from the granted requester; proc2mem_data = proc2Dmem_data on dcache grant, 0 otherwise.
REQ-015 SHALL route mem2proc_response to the granted side's *_response; the non-granted side SHALL see response 0 (treated as busy, retry).
REQ-016 SHALL keep a 15-entry owner table indexed by tag 1..15 (valid, owner bit); entry for tag 0 never exists.
REQ-017 SHALL on posedge with grant and mem2proc_response != 0 set entry[response] valid, owner = granted side.
REQ-018 SHALL when mem2proc_tag != 0 and entry valid, drive that tag and mem2proc_data to the owner's *_tag/*_data and clear the entry on posedge; the other side sees tag 0, data 0.
REQ-019 SHALL when mem2proc_tag != 0 and entry invalid, drive tag 0 to both sides and pulse orphan_tag next cycle.
REQ-020 SHALL when completion tag equals newly issued response tag same cycle, route completion to old owner, then install new owner (allocate wins final state).
REQ-021 SHALL allocation to an already-valid entry overwrite it and pulse orphan_tag.
REQ-022 SHALL I_outstanding/D_outstanding equal count of valid entries per owner, updated on posedge, no wrap (max 15).
REQ-023 SHALL BUS_STORE grants allocate no entry even if response nonzero.

Reset
REQ-024 SHALL on reset low clear owner table, counters, starvation counter, orphan_tag immediately (async).
REQ-025 SHALL while reset low force proc2mem_command BUS_NONE, addr/data 0, all *_response/*_tag/*_data 0.
REQ-026 SHALL on reset deassertion mid-transaction lose in-flight tags; later completions count as orphans.

Configuration
REQ-027 SHALL with ARB_STARVE_GUARD_EN defined: count consecutive cycles icache requests but is not granted (or granted with response 0); at STARVE_LIMIT grant icache over dcache for one cycle, then clear counter; clear counter on any icache grant with nonzero response.
REQ-028 SHALL without ARB_STARVE_GUARD_EN: pure fixed dcache priority per REQ-013, no starvation counter.

Verification
REQ-029 SHALL test: icache LOAD 0x100 alone, mem response 3 -> Imem2proc_response=3, D side 0; later mem tag 3 data 0xABCD -> Imem2proc_tag=3, data 0xABCD, I_outstanding 1->0.
REQ-030 SHALL test: both LOAD same cycle, response 5 -> Dmem2proc_response=5, Imem2proc_response=0, proc2mem_addr = dcache addr.
REQ-031 SHALL test: completion tag 7 issued to dcache, same cycle new icache grant response 7 -> Dmem2proc_tag=7 this cycle; next cycle entry 7 owned by icache.
REQ-032 SHALL test: mem2proc_tag 9 never issued -> both tags 0, orphan_tag=1 one cycle later for one cycle.
REQ-033 SHALL test (guard build, STARVE_LIMIT=4): dcache requests continuously, icache continuously -> icache granted on 5th cycle only; without macro never granted.
REQ-034 SHALL test: reset low asynchronously with 3 tags outstanding -> outputs 0 without clock edge; after release, completion of old tag pulses orphan_tag.
